// File: rtl/exec_entry_pkg.sv
// Shared execution-queue entry layout, widths and issue-stage state encoding.
// The dispatch stage and the execution queue use the same field constants.
package exec_entry_pkg;
  localparam int ENTRY_W = 128;
  localparam int TAG_W   = 6;
  localparam int XLEN    = 32;

  localparam int RD_TAG_LSB   = 0;
  localparam int RD_TAG_MSB   = 5;
  localparam int RS2_TAG_LSB  = 6;
  localparam int RS2_TAG_MSB  = 11;
  localparam int RS2_V_BIT    = 12;
  localparam int RS2_DATA_LSB = 13;
  localparam int RS2_DATA_MSB = 44;
  localparam int RS1_TAG_LSB  = 45;
  localparam int RS1_TAG_MSB  = 50;
  localparam int RS1_V_BIT    = 51;
  localparam int RS1_DATA_LSB = 52;
  localparam int RS1_DATA_MSB = 83;
  localparam int OP_LSB       = 84;
  localparam int OP_MSB       = 87;
  localparam int IMM_LSB      = 88;
  localparam int IMM_MSB      = 119;
  localparam int USE_IMM_BIT  = 120;

  typedef enum logic [1:0] {EMPTY, WAIT, READY} issue_state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [TAG_W-1:0] rd;
  } issue_ctl_t;
endpackage

// File: rtl/cdb_snoop.sv
// Per-operand CDB snoop: tag compare plus the valid/data update mux.
module cdb_snoop #(
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic             cur_valid,
  input  logic [TAG_W-1:0] cur_tag,
  input  logic [XLEN-1:0]  cur_data,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             nxt_valid,
  output logic [XLEN-1:0]  nxt_data
);
  logic hit;

  // An already-valid operand must never be overwritten by a stale tag reuse.
  assign hit       = cdb_valid & ~cur_valid & (cdb_tag == cur_tag);
  assign nxt_valid = cur_valid | hit;
  assign nxt_data  = hit ? cdb_data : cur_data;
endmodule

// File: rtl/exec_issue_stage.sv
// Issue stage: pops one queue entry into a hold register, snoops the CDB until
// both operands are valid, then offers it to the integer FU over valid/ready.
module exec_issue_stage
  import exec_entry_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic [ENTRY_W-1:0] i_q_data,
  input  logic               i_q_empty,
  output logic               o_q_rd_en,
  input  logic               i_cdb_valid,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic [XLEN-1:0]    i_cdb_data,
  output logic               o_fu_valid,
  input  logic               i_fu_ready,
  output logic [3:0]         o_fu_op,
  output logic [XLEN-1:0]    o_fu_a,
  output logic [XLEN-1:0]    o_fu_b,
  output logic [TAG_W-1:0]   o_fu_tag,
  output logic [15:0]        o_stall_cnt
);
  localparam int NUM_SRC = 2;  // index 0 = rs1 / A, index 1 = rs2 / B

  issue_state_e                  st_q, st_d;
  logic                          pop, use_imm, unused_rsvd;
  logic [NUM_SRC-1:0]            src_v, cur_v, nxt_v, hold_v;
  logic [NUM_SRC-1:0][TAG_W-1:0] src_tag, cur_tag, hold_tag;
  logic [NUM_SRC-1:0][XLEN-1:0]  src_data, cur_data, nxt_data, hold_data;
  issue_ctl_t                    src_ctl, hold_ctl;
  logic [15:0]                   stall_cnt;

  // An immediate replaces rs2 outright, so B is born ready.
  assign use_imm  = i_q_data[USE_IMM_BIT];
  assign src_v    = {use_imm | i_q_data[RS2_V_BIT], i_q_data[RS1_V_BIT]};
  assign src_tag  = {i_q_data[RS2_TAG_MSB:RS2_TAG_LSB], i_q_data[RS1_TAG_MSB:RS1_TAG_LSB]};
  assign src_data = {use_imm ? i_q_data[IMM_MSB:IMM_LSB] : i_q_data[RS2_DATA_MSB:RS2_DATA_LSB],
                     i_q_data[RS1_DATA_MSB:RS1_DATA_LSB]};
  assign src_ctl  = '{op: i_q_data[OP_MSB:OP_LSB], rd: i_q_data[RD_TAG_MSB:RD_TAG_LSB]};
  assign unused_rsvd = ^i_q_data[ENTRY_W-1:USE_IMM_BIT+1];

  // Snoop the incoming entry on a pop, otherwise the held one.
  assign cur_v    = pop ? src_v    : hold_v;
  assign cur_tag  = pop ? src_tag  : hold_tag;
  assign cur_data = pop ? src_data : hold_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_snoop #(.TAG_W(TAG_W), .XLEN(XLEN)) u_snoop (
      .cur_valid (cur_v[g]),
      .cur_tag   (cur_tag[g]),
      .cur_data  (cur_data[g]),
      .cdb_valid (i_cdb_valid),
      .cdb_tag   (i_cdb_tag),
      .cdb_data  (i_cdb_data),
      .nxt_valid (nxt_v[g]),
      .nxt_data  (nxt_data[g])
    );
  end

  always_comb begin
    st_d       = st_q;
    o_fu_valid = (st_q == READY) & ~i_flush;
    // Reset gating keeps the queue from popping into a register held in reset.
    pop = i_rst_n & ~i_flush & ~i_q_empty &
          ((st_q == EMPTY) | ((st_q == READY) & i_fu_ready));
    if (i_flush)                           st_d = EMPTY;
    else if (pop)                          st_d = (&nxt_v) ? READY : WAIT;
    else if (st_q == WAIT && (&nxt_v))     st_d = READY;
    else if (st_q == READY && i_fu_ready)  st_d = EMPTY;
  end

  assign o_q_rd_en = pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q      <= EMPTY;
      hold_v    <= '0;
      hold_tag  <= '0;
      hold_data <= '0;
      hold_ctl  <= '0;
      stall_cnt <= '0;
    end else begin
      st_q <= st_d;
      if (pop) begin
        hold_v    <= nxt_v;
        hold_tag  <= cur_tag;
        hold_data <= nxt_data;
        hold_ctl  <= src_ctl;
      end else if (st_q == WAIT && !i_flush) begin
        hold_v    <= nxt_v;
        hold_data <= nxt_data;
      end
      if (st_q == WAIT && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_fu_a      = hold_data[0];
  assign o_fu_b      = hold_data[1];
  assign o_fu_op     = hold_ctl.op;
  assign o_fu_tag    = hold_ctl.rd;
  assign o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_exec_issue_stage.sv
// Directed bench for exec_issue_stage: queue model feeds entries, a scoreboard
// of expected FU transfers is checked at every handshake.
module tb_exec_issue_stage;
  logic         i_clk, i_rst_n, i_flush, i_q_empty, o_q_rd_en;
  logic [127:0] i_q_data;
  logic         i_cdb_valid, o_fu_valid, i_fu_ready;
  logic [5:0]   i_cdb_tag, o_fu_tag;
  logic [31:0]  i_cdb_data, o_fu_a, o_fu_b;
  logic [3:0]   o_fu_op;
  logic [15:0]  o_stall_cnt;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
  } exp_t;

  logic [127:0] q_mem[$];
  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [5:0]   pop_hist, acc_hist;
  logic [31:0]  held_a;

  exec_issue_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_q_data(i_q_data),
    .i_q_empty(i_q_empty), .o_q_rd_en(o_q_rd_en), .i_cdb_valid(i_cdb_valid),
    .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data), .o_fu_valid(o_fu_valid),
    .i_fu_ready(i_fu_ready), .o_fu_op(o_fu_op), .o_fu_a(o_fu_a), .o_fu_b(o_fu_b),
    .o_fu_tag(o_fu_tag), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [5:0] rd, input logic v1, input logic [5:0] t1,
                                      input logic [31:0] d1, input logic v2, input logic [5:0] t2,
                                      input logic [31:0] d2, input logic [3:0] op,
                                      input logic [31:0] imm, input logic ui);
    logic [127:0] e;
    e = '0;
    e[5:0] = rd;    e[11:6] = t2;   e[12] = v2;     e[44:13] = d2;
    e[50:45] = t1;  e[51] = v1;     e[83:52] = d1;  e[87:84] = op;
    e[119:88] = imm; e[120] = ui;   e[127:121] = 7'h55;
    return e;
  endfunction

  task automatic upd_q();
    i_q_empty = (q_mem.size() == 0);
    i_q_data  = i_q_empty ? '0 : q_mem[0];
  endtask

  task automatic add(input logic [5:0] rd, input logic v1, input logic [5:0] t1,
                     input logic [31:0] d1, input logic v2, input logic [5:0] t2,
                     input logic [31:0] d2, input logic [3:0] op, input logic [31:0] imm,
                     input logic ui, input logic [31:0] ea, input logic [31:0] eb);
    q_mem.push_back(mk(rd, v1, t1, d1, v2, t2, d2, op, imm, ui));
    exp_q.push_back('{op: op, a: ea, b: eb, tag: rd});
    upd_q();
  endtask

  // One clock: score any FU transfer, then advance the queue model on a pop.
  task automatic tick(output logic popped, output logic accepted);
    exp_t e;
    #1;
    accepted = (o_fu_valid === 1'b1) && i_fu_ready;
    popped   = (o_q_rd_en === 1'b1);
    if (accepted) begin
      chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_a", o_fu_a, e.a);
        chk("sb_b", o_fu_b, e.b);
        chk("sb_op", {28'd0, o_fu_op}, {28'd0, e.op});
        chk("sb_tag", {26'd0, o_fu_tag}, {26'd0, e.tag});
      end
    end
    @(posedge i_clk); #1;
    if (popped && q_mem.size() > 0) void'(q_mem.pop_front());
    upd_q();
  endtask

  initial begin
    logic p, a;
    i_rst_n = 0; i_flush = 0; i_cdb_valid = 0; i_cdb_tag = '0; i_cdb_data = '0;
    i_fu_ready = 1; upd_q();

    // Reset: outputs clear and no pop even though the queue holds an entry.
    add(6'd3, 1, 6'd0, 32'h5, 1, 6'd0, 32'h7, 4'h2, 32'h0, 0, 32'h5, 32'h7);
    #12;
    chk("rst_rd_en", {31'd0, o_q_rd_en}, 32'd0);
    chk("rst_valid", {31'd0, o_fu_valid}, 32'd0);
    chk("rst_a", o_fu_a, 32'd0);
    chk("rst_stall", {16'd0, o_stall_cnt}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1; #1;

    // Both operands ready: valid one cycle after the pop.
    chk("t1_rd_en", {31'd0, o_q_rd_en}, 32'd1);
    tick(p, a);
    chk("t1_valid", {31'd0, o_fu_valid}, 32'd1);
    tick(p, a);
    chk("t1_idle", {31'd0, o_fu_valid}, 32'd0);

    // rs1 pending on tag 0x12, CDB arrives three cycles after the pop.
    add(6'd4, 0, 6'h12, 32'h0, 1, 6'd0, 32'h11, 4'h1, 32'h0, 0, 32'hDEADBEEF, 32'h11);
    tick(p, a); tick(p, a); tick(p, a);
    chk("t2_wait", {31'd0, o_fu_valid}, 32'd0);
    i_cdb_valid = 1; i_cdb_tag = 6'h12; i_cdb_data = 32'hDEADBEEF;
    tick(p, a);
    i_cdb_valid = 0;
    chk("t2_valid", {31'd0, o_fu_valid}, 32'd1);
    chk("t2_stall", {16'd0, o_stall_cnt}, 32'd3);
    tick(p, a);

    // Same-cycle CDB on pop satisfies both operands sharing tag 9.
    add(6'd5, 0, 6'd9, 32'h0, 0, 6'd9, 32'h0, 4'h7, 32'h0, 0, 32'hAA, 32'hAA);
    i_cdb_valid = 1; i_cdb_tag = 6'd9; i_cdb_data = 32'hAA;
    tick(p, a);
    i_cdb_valid = 0;
    chk("t3_valid", {31'd0, o_fu_valid}, 32'd1);
    chk("t3_stall", {16'd0, o_stall_cnt}, 32'd3);
    tick(p, a);

    // Back-to-back issue, one entry using an immediate for B.
    add(6'd10, 1, 6'd0, 32'h100, 1, 6'd0, 32'h200, 4'h3, 32'h0, 0, 32'h100, 32'h200);
    add(6'd11, 1, 6'd0, 32'h101, 0, 6'h3F, 32'h0, 4'h4, 32'h1234, 1, 32'h101, 32'h1234);
    add(6'd12, 1, 6'd0, 32'h102, 1, 6'd0, 32'h202, 4'h5, 32'h0, 0, 32'h102, 32'h202);
    add(6'd13, 1, 6'd0, 32'h103, 1, 6'd0, 32'h203, 4'h6, 32'h0, 0, 32'h103, 32'h203);
    pop_hist = '0; acc_hist = '0;
    for (int i = 0; i < 6; i++) begin
      tick(p, a);
      pop_hist[i] = p; acc_hist[i] = a;
    end
    chk("t4_pops", {26'd0, pop_hist}, 32'b001111);
    chk("t4_accepts", {26'd0, acc_hist}, 32'b011110);

    // FU stalls two cycles in READY, then accept coincides with the next pop.
    add(6'd20, 1, 6'd0, 32'h55, 1, 6'd0, 32'h66, 4'h8, 32'h0, 0, 32'h55, 32'h66);
    add(6'd21, 1, 6'd0, 32'h77, 1, 6'd0, 32'h88, 4'h9, 32'h0, 0, 32'h77, 32'h88);
    i_fu_ready = 0;
    tick(p, a);
    held_a = o_fu_a;
    for (int i = 0; i < 2; i++) begin
      chk("t5_hold_valid", {31'd0, o_fu_valid}, 32'd1);
      chk("t5_hold_a", o_fu_a, 32'h55);
      chk("t5_no_pop", {31'd0, o_q_rd_en}, 32'd0);
      tick(p, a);
    end
    chk("t5_stable_a", o_fu_a, held_a);
    i_fu_ready = 1; #1;
    chk("t5_pop_on_accept", {31'd0, o_q_rd_en}, 32'd1);
    tick(p, a);
    chk("t5_next_valid", {31'd0, o_fu_valid}, 32'd1);
    tick(p, a);
    chk("t5_idle", {31'd0, o_fu_valid}, 32'd0);

    // Flush in READY with a CDB broadcast in flight drops the held entry.
    add(6'd30, 1, 6'd0, 32'h31, 1, 6'd0, 32'h32, 4'hA, 32'h0, 0, 32'h31, 32'h32);
    i_fu_ready = 0;
    tick(p, a);
    add(6'd31, 1, 6'd0, 32'h41, 1, 6'd0, 32'h42, 4'hB, 32'h0, 0, 32'h41, 32'h42);
    i_flush = 1; i_cdb_valid = 1; i_cdb_tag = 6'h21; i_cdb_data = 32'hFEED; #1;
    chk("t6_flush_valid", {31'd0, o_fu_valid}, 32'd0);
    chk("t6_flush_nopop", {31'd0, o_q_rd_en}, 32'd0);
    void'(exp_q.pop_front());
    i_fu_ready = 1;
    tick(p, a);
    i_flush = 0; i_cdb_valid = 0; #1;
    chk("t6_empty", {31'd0, o_fu_valid}, 32'd0);
    chk("t6_refill", {31'd0, o_q_rd_en}, 32'd1);
    tick(p, a);
    chk("t6_reissue", {31'd0, o_fu_valid}, 32'd1);
    tick(p, a);

    // Async reset while in WAIT clears everything immediately.
    add(6'h3A, 0, 6'h30, 32'h0, 1, 6'd0, 32'h99, 4'hC, 32'h0, 0, 32'h0, 32'h99);
    tick(p, a); tick(p, a);
    chk("t7_wait", {31'd0, o_fu_valid}, 32'd0);
    chk("t7_stall", {16'd0, o_stall_cnt}, 32'd4);
    chk("t7_b_pre", o_fu_b, 32'h99);
    void'(exp_q.pop_front());
    add(6'd7, 1, 6'd0, 32'hC1, 1, 6'd0, 32'hC2, 4'hD, 32'h0, 0, 32'hC1, 32'hC2);
    i_rst_n = 0; #1;
    chk("t7_rst_valid", {31'd0, o_fu_valid}, 32'd0);
    chk("t7_rst_b", o_fu_b, 32'd0);
    chk("t7_rst_tag", {26'd0, o_fu_tag}, 32'd0);
    chk("t7_rst_op", {28'd0, o_fu_op}, 32'd0);
    chk("t7_rst_stall", {16'd0, o_stall_cnt}, 32'd0);
    chk("t7_rst_rd_en", {31'd0, o_q_rd_en}, 32'd0);
    tick(p, a);
    i_rst_n = 1; #1;
    chk("t7_resume_pop", {31'd0, o_q_rd_en}, 32'd1);
    tick(p, a);
    chk("t7_resume_valid", {31'd0, o_fu_valid}, 32'd1);
    tick(p, a);

    chk("sb_drained", exp_q.size(), 32'd0);
    chk("q_drained", q_mem.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exec_issue_stage.md
# exec_issue_stage

Downstream consumer of the execution queue in the RISC-V out-of-order core. It pops one 128-bit reservation entry at a time into a local hold register and snoops the CDB until both source operands are valid. It then presents the instruction to the integer functional unit over a valid/ready handshake. It also gives the queue a combinational read enable, because the queue only drives `data_out` while `rd_en` is high.

## Interface
- `ENTRY_W`, 128: queue entry width.
- `TAG_W`, 6: CDB/ROB tag width.
- `XLEN`, 32: operand width.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_flush` in 1: pipeline flush (branch mispredict).
- `i_q_data` in ENTRY_W: queue head data, valid only while `o_q_rd_en`=1.
- `i_q_empty` in 1: queue empty.
- `o_q_rd_en` out 1: pop queue head; combinational.
- `i_cdb_valid` in 1: CDB broadcast valid.
- `i_cdb_tag` in TAG_W: CDB tag.
- `i_cdb_data` in XLEN: CDB data.
- `o_fu_valid` out 1: instruction offered to the FU.
- `i_fu_ready` in 1: FU accepts.
- `o_fu_op` out 4: ALU opcode.
- `o_fu_a` out XLEN: operand A.
- `o_fu_b` out XLEN: operand B.
- `o_fu_tag` out TAG_W: destination tag.
- `o_stall_cnt` out 16: saturating count of cycles in WAIT.

## Operation
- Entry fields:
  - [5:0] rd tag
  - [11:6] rs2 tag
  - [12] rs2 valid
  - [44:13] rs2 data
  - [50:45] rs1 tag
  - [51] rs1 valid
  - [83:52] rs1 data
  - [87:84] op
  - [119:88] imm
  - [120] use_imm
  - [127:121] reserved, ignored
- Queue contract: entries still held in the queue have their valid bits set by the queue on CDB capture. This block snoops only the entry it is holding and the entry being popped.
- States:
  - EMPTY: hold register invalid.
  - WAIT: holding an entry with at least one operand not ready.
  - READY: both operands ready, `o_fu_valid`=1.
- Operand ready: valid bit set, or `i_cdb_valid` with tag equal and valid bit clear. On that CDB match, latch `i_cdb_data` and set the valid bit.
- When use_imm=1, operand B = imm and rs2 is ready unconditionally.
- `o_q_rd_en` = !i_flush & !i_q_empty & (state==EMPTY | (state==READY & i_fu_ready)). This allows back-to-back issue.
- Capture on pop: store `i_q_data`, applying the same-cycle CDB snoop to both operands. Next state is READY if both are ready after snoop, otherwise WAIT.
- WAIT -> READY when the last missing operand matches the CDB.
- READY & `i_fu_ready` & no pop -> EMPTY.
- While in READY, the outputs are stable until accepted. No CDB update is needed since both operands are already valid.
- One CDB broadcast may satisfy both operands when rs1 tag == rs2 tag.
- Flush: in the cycle it is asserted, `o_fu_valid` is forced 0, no pop occurs, and the next state is EMPTY. Flush wins over every other event.
- `o_stall_cnt`: +1 each cycle in WAIT, saturates at 0xFFFF, cleared only by reset.

## Timing
- Reset (async):
  - state=EMPTY
  - `o_fu_valid`=0
  - `o_fu_a`/`o_fu_b`/`o_fu_op`/`o_fu_tag`=0
  - `o_stall_cnt`=0
  - `o_q_rd_en`=0 while `i_rst_n`=0
- Pop at cycle t with both operands ready (including a CDB hit at t): `o_fu_valid`=1 at t+1.
- CDB hit for the missing operand at cycle t while in WAIT: `o_fu_valid`=1 at t+1.
- Sustained throughput: 1 instruction/cycle when the FU is always ready and operands are ready.
- FU handshake:
  - Transfer occurs when `o_fu_valid` & `i_fu_ready` at a rising edge.
  - `o_fu_valid` never drops without a transfer, except on flush or reset.
- Reset deasserting mid-operation: the block resumes from EMPTY, with no stale issue.

## Structure
- Package `exec_entry_pkg` holds:
  - ENTRY_W, TAG_W, XLEN
  - field LSB/MSB localparams listed above
  - state enum {EMPTY, WAIT, READY}
- The same field constants are shared with the execution queue and the dispatch stage.
- Sub-module `cdb_snoop` (one per operand) holds the tag compare and the data/valid update mux. It takes the current valid/tag/data plus the CDB and returns the next valid and data. It is instantiated twice.

## Test plan
- Reset, then pop an entry with rs1 valid (0x5), rs2 valid (0x7), rd tag 3 -> `o_fu_valid`=1 one cycle after the pop; A=0x5, B=0x7, tag=3.
- Entry with rs1 pending on tag 0x12; CDB(0x12, 0xDEADBEEF) three cycles later -> WAIT for 3 cycles, `o_stall_cnt`=3, then issue with A=0xDEADBEEF.
- CDB (tag 9, data 0xAA) in the same cycle as a pop of an entry whose rs1 and rs2 both wait on tag 9 -> next cycle A=B=0xAA and `o_fu_valid`=1.
- Four ready entries with FU ready held high -> four issues on consecutive cycles; `o_q_rd_en` high for 4 cycles.
- `i_fu_ready`=0 for 2 cycles while READY -> outputs held and no pop; accepted on the third cycle with the next pop in the same cycle.
- Flush while READY with a CDB hit pending -> `o_fu_valid`=0 that cycle and next state EMPTY; a new entry then issues normally. Reset asserted in WAIT -> all outputs 0 immediately.
